// File: rtl/wb_stage_regfile.sv
// Write-back stage register file: selects the write-back value, stores it into a
// 32x32 register file with write-through reads, and counts committed writes.
module wb_stage_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WB_RegWrite,
    input  logic [1:0]        WB_MemToReg,
    input  logic              WB_halfbyte,
    input  logic [DATA_W-1:0] WB_PCAddResult,
    input  logic [DATA_W-1:0] WB_Read,
    input  logic [DATA_W-1:0] WB_ALUResult,
    input  logic [4:0]        WB_RegDst,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic [31:0]       WriteCount
);

    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] mem_value;
    logic              write_en;

    function automatic logic [DATA_W-1:0] sext_half(input logic [DATA_W-1:0] v);
        logic signed [15:0] half;
        half = v[15:0];
        return DATA_W'(half);
    endfunction

    always_comb begin
        mem_value = WB_halfbyte ? sext_half(WB_Read) : WB_Read;
        case (WB_MemToReg)
            2'b01:   WB_WriteData = mem_value;
            2'b10:   WB_WriteData = WB_PCAddResult;
            default: WB_WriteData = WB_ALUResult;
        endcase
    end

    // Index 0 is hardwired, so a write aimed at it is never committed or counted.
    assign write_en = WB_RegWrite && (WB_RegDst != 5'd0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            WriteCount <= '0;
        end else if (write_en) begin
            regs[WB_RegDst] <= WB_WriteData;
            WriteCount      <= WriteCount + 32'd1;
        end
    end

    // Bypass lets ID see this cycle's write-back; it is muted while in reset.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (Reset) begin
            if (ReadRegister1 != 5'd0) begin
                ReadData1 = (write_en && WB_RegDst == ReadRegister1) ? WB_WriteData
                                                                     : regs[ReadRegister1];
            end
            if (ReadRegister2 != 5'd0) begin
                ReadData2 = (write_en && WB_RegDst == ReadRegister2) ? WB_WriteData
                                                                     : regs[ReadRegister2];
            end
        end
    end

endmodule
